// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer line fetcher.
package fb_pkg;

  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int H_TOTAL       = 800;
  localparam int V_TOTAL       = 525;
  localparam int WORDS_PER_ROW = 80;

  // One palette entry / output pixel, packed as {r,g,b}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Row fetch engine state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Grey-ramp colour for palette index i: each channel is i*17, which for a
  // 4-bit index is simply the nibble repeated.
  function automatic rgb_t grey_entry(input logic [3:0] i);
    rgb_t c;
    c.r = {i, i};
    c.g = {i, i};
    c.b = {i, i};
    return c;
  endfunction

endpackage

// File: rtl/fb_palette.sv
// 16-entry x 24-bit palette: one synchronous write port, one combinational
// read port. Reset loads a grey ramp so the display is usable before software
// programs any colours.
module fb_palette
  import fb_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       we_i,
  input  logic [3:0] wr_addr_i,
  input  rgb_t       wr_data_i,
  input  logic [3:0] rd_addr_i,
  output rgb_t       rd_data_o
);

  rgb_t pal_q [16];

  // Register file: grey ramp on reset, single write port afterwards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= grey_entry(4'(i));
      end
    end else if (we_i) begin
      pal_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A write is seen by the reader on the following cycle.
  assign rd_data_o = pal_q[rd_addr_i];

endmodule

// File: rtl/fb_line_fetcher.sv
// Framebuffer line fetcher: during horizontal blanking it reads the next
// 320-pixel row (80 words, 4 bits per pixel) into a line buffer, then plays
// it back doubled in both directions through the palette to the DAC.
//
// Memory handshake: mem_req is raised with a stable mem_addr and held until
// mem_ack is seen; a mem_ack cycle both delivers mem_rdata and consumes the
// request, after which the next address (or a dropped mem_req) follows on
// the next cycle. mem_ack while no request is outstanding is ignored.
module fb_line_fetcher
  import fb_pkg::*;
#(
  parameter int                ADDR_W        = 20,
  parameter logic [ADDR_W-1:0] FB_BASE       = '0,
  parameter int                WORDS_PER_ROW = 80
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              pal_we,
  input  logic [3:0]        pal_addr,
  input  logic [23:0]       pal_data,
  input  logic              underrun_clr,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              underrun,
  output fetch_state_t      dbg_state_o
);

  localparam int IDX_W = $clog2(WORDS_PER_ROW);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_FETCH = FETCH;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              underrun_q, underrun_d;
  logic [9:0]        prev_x_q;

  logic [15:0]       line_buf [WORDS_PER_ROW];

  // Line trigger and target-row arithmetic.
  logic              trigger;
  logic [9:0]        ny;
  logic              need_fetch;
  logic [ADDR_W-1:0] row_base;
  logic              last_word;
  logic              abort;
  logic              buf_we;

  assign trigger    = (DrawX == 10'd640) && (prev_x_q != 10'd640);
  assign ny         = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
  assign need_fetch = (ny < 10'd480) && !ny[0];
  // row*80 built from two shifts so no multiplier is needed.
  assign row_base   = FB_BASE + (ADDR_W'(ny[9:1]) << 6) + (ADDR_W'(ny[9:1]) << 4);
  assign last_word  = (idx_q == IDX_W'(WORDS_PER_ROW - 1));
  assign abort      = (state_q == ST_FETCH) && (DrawX == 10'd0);
  assign buf_we     = (state_q == ST_FETCH) && mem_ack;

  // Fetch FSM next-state: start on a qualifying trigger, step on each ack,
  // give up (and flag it) if the visible line starts first.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mem_req_d  = mem_req_q;
    addr_d     = addr_q;
    underrun_d = underrun_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger && need_fetch) begin
          state_d   = ST_FETCH;
          idx_d     = '0;
          mem_req_d = 1'b1;
          addr_d    = row_base;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else if (mem_ack) begin
          if (last_word) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    // An abort wins over a simultaneous clear so the event is never lost.
    if (abort) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // Fetch FSM and flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mem_req_q  <= 1'b0;
      addr_q     <= '0;
      underrun_q <= 1'b0;
      prev_x_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mem_req_q  <= mem_req_d;
      addr_q     <= addr_d;
      underrun_q <= underrun_d;
      prev_x_q   <= DrawX;
    end
  end

  // Line buffer capture; contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (buf_we) begin
      line_buf[idx_q] <= mem_rdata;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;
  assign underrun    = underrun_q;
  assign dbg_state_o = fetch_state_t'(state_q);

  // Display stage 1: framebuffer pixel px = DrawX>>1 lives in word px>>2 at
  // nibble px[1:0]; nibble 0 is the leftmost pixel.
  logic [6:0]  rd_word;
  logic [15:0] rd_data;
  logic [15:0] word_q;
  logic [1:0]  sel_q;
  logic        blank_q;

  assign rd_word = DrawX[9:3];
  assign rd_data = (rd_word < 7'(WORDS_PER_ROW)) ? line_buf[IDX_W'(rd_word)] : 16'h0000;

  // Stage 1 registers: buffer word, nibble select and delayed blank.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      word_q  <= '0;
      sel_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      word_q  <= rd_data;
      sel_q   <= DrawX[2:1];
      blank_q <= blank;
    end
  end

  // Display stage 2: palette lookup, forced black outside the active area.
  logic [3:0] nibble;
  rgb_t       pal_rgb;
  rgb_t       rgb_q;

  always_comb begin
    nibble = word_q[3:0];
    case (sel_q)
      2'd0:    nibble = word_q[3:0];
      2'd1:    nibble = word_q[7:4];
      2'd2:    nibble = word_q[11:8];
      default: nibble = word_q[15:12];
    endcase
  end

  fb_palette u_palette (
    .Clk       (Clk),
    .Reset     (Reset),
    .we_i      (pal_we),
    .wr_addr_i (pal_addr),
    .wr_data_i (rgb_t'(pal_data)),
    .rd_addr_i (nibble),
    .rd_data_o (pal_rgb)
  );

  // Output colour register driving the DAC.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= blank_q ? pal_rgb : '0;
    end
  end

  assign VGA_R = rgb_q.r;
  assign VGA_G = rgb_q.g;
  assign VGA_B = rgb_q.b;

endmodule

// File: tb/tb_fb_line_fetcher.sv
// Bench for fb_line_fetcher: scripted line timing with a randomised-latency
// memory responder, and a pixel-level model of line buffer and palette.
module tb_fb_line_fetcher;
  import fb_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         Clk = 1'b0;
  logic         Reset;
  logic [9:0]   DrawX, DrawY;
  logic         blank;
  logic         mem_req;
  logic [19:0]  mem_addr;
  logic         mem_ack;
  logic [15:0]  mem_rdata;
  logic         pal_we;
  logic [3:0]   pal_addr;
  logic [23:0]  pal_data;
  logic         underrun_clr;
  logic [7:0]   VGA_R, VGA_G, VGA_B;
  logic         underrun;
  fetch_state_t dbg_state;

  always #10 Clk = ~Clk;

  fb_line_fetcher dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .pal_we       (pal_we),
    .pal_addr     (pal_addr),
    .pal_data     (pal_data),
    .underrun_clr (underrun_clr),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .underrun     (underrun),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- reference model state ----------------
  localparam int MEM_WORDS = 240 * 80;
  logic [15:0] mem_img   [MEM_WORDS];
  logic [15:0] model_buf [80];
  logic [23:0] pal_m     [16];
  logic [19:0] got_addr_q[$];
  logic [23:0] exp_q[$];
  int          ack_gap;
  int          gap_cnt;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [23:0] grey24(input int i);
    logic [7:0] v;
    v = 8'(i * 17);
    return {v, v, v};
  endfunction

  // Colour the screen should show for horizontal position x.
  function automatic logic [23:0] pixel_model(input int x, input logic bl);
    int          px;
    logic [15:0] w;
    logic [3:0]  idx;
    if (!bl) return 24'h000000;
    px  = x / 2;
    w   = model_buf[px / 4];
    idx = 4'((w >> (4 * (px % 4))) & 16'hF);
    return pal_m[idx];
  endfunction

  // A complete (or partial) fetch of `row` deposits words 0..n-1.
  task automatic model_fill(input int row, input int n);
    for (int k = 0; k < n; k++) model_buf[k] = mem_img[row * 80 + k];
  endtask

  // ---------------- driver: one clock + memory responder ----------------
  task automatic step();
    @(posedge Clk);
    #1;
    mem_ack      = 1'b0;
    pal_we       = 1'b0;
    underrun_clr = 1'b0;
    if (mem_req && !Reset) begin
      gap_cnt++;
      if (gap_cnt >= ack_gap) begin
        gap_cnt   = 0;
        mem_ack   = 1'b1;
        mem_rdata = (mem_addr < 20'(MEM_WORDS)) ? mem_img[mem_addr] : 16'hDEAD;
        got_addr_q.push_back(mem_addr);
      end
    end else begin
      gap_cnt = 0;
    end
  endtask

  // Horizontal blanking of line y: DrawX 640..799 (2 Clk each) then 0.
  task automatic hblank(input int y, input int gap, input bit clr_at_abort,
                        output int acks);
    DrawY   = 10'(y);
    blank   = 1'b0;
    ack_gap = gap;
    gap_cnt = 0;
    got_addr_q.delete();
    DrawX = 10'd639;
    step();
    step();
    for (int x = 640; x < 800; x++) begin
      DrawX = 10'(x);
      step();
      step();
    end
    DrawX = 10'd0;
    if (clr_at_abort) underrun_clr = 1'b1;
    step();
    acks = got_addr_q.size();
  endtask

  task automatic check_addrs(input string name, input int row, input int n);
    for (int k = 0; k < n && k < got_addr_q.size(); k++) begin
      checks++;
      if (got_addr_q[k] !== 20'(row * 80 + k)) begin
        errors++;
        $display("FAIL %s addr[%0d]: got %h expected %h", name, k, got_addr_q[k],
                 20'(row * 80 + k));
      end
    end
  endtask

  // ---------------- scoreboard for the pixel pipeline ----------------
  task automatic pix(input int x, input logic bl);
    exp_q.push_back(pixel_model(x, bl));
    DrawX = 10'(x);
    blank = bl;
    step();
    if (exp_q.size() == 2) pix_check();
  endtask

  task automatic pix_check();
    logic [23:0] e;
    e = exp_q.pop_front();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== e) begin
      errors++;
      $display("FAIL pixel: got %h expected %h", {VGA_R, VGA_G, VGA_B}, e);
    end
  endtask

  task automatic pix_flush();
    if (exp_q.size() == 1) begin
      step();
      pix_check();
    end
  endtask

  task automatic pixel_stream(input int n, input bit pal_writes);
    for (int i = 0; i < n; i++) begin
      if (pal_writes && $urandom_range(0, 7) == 0) begin
        pal_we   = 1'b1;
        pal_addr = 4'($urandom_range(0, 15));
        pal_data = 24'($urandom);
        pal_m[pal_addr] = pal_data;
      end
      pix($urandom_range(0, 639), $urandom_range(0, 3) != 0);
    end
    pix_flush();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req: got %b expected 0", mem_req); end
    checks++;
    if (mem_addr !== 20'h0) begin errors++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      errors++; $display("FAIL reset rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B});
    end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset underrun: got %b expected 0", underrun); end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset state: got %0d expected IDLE", dbg_state); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_line_fetch();
    int acks;
    hblank(1, 1, 1'b0, acks);
    checks++;
    if (acks !== 80) begin errors++; $display("FAIL fetch count: got %0d expected 80", acks); end
    check_addrs("fetch", 1, 80);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch req_done: got %b expected 0", mem_req); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL fetch underrun: got %b expected 0", underrun); end
    model_fill(1, acks);
  endtask

  task automatic test_odd_skip_wrap();
    int acks;
    hblank(2, 1, 1'b0, acks);
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL odd_skip count: got %0d expected 0", acks); end
    hblank(524, 2, 1'b0, acks);
    checks++;
    if (acks !== 80) begin errors++; $display("FAIL wrap count: got %0d expected 80", acks); end
    check_addrs("wrap", 0, 80);
    model_fill(0, acks);
  endtask

  task automatic test_pixel_path();
    DrawY = 10'd0;
    for (int x = 0; x < 8; x++) pix(x, 1'b1);
    pix_flush();
    pixel_stream(200, 1'b0);
  endtask

  task automatic test_blank_palette();
    pix(6, 1'b0);
    pix(6, 1'b1);
    pix_flush();
    pal_we   = 1'b1;
    pal_addr = 4'd2;
    pal_data = 24'hFF0000;
    pal_m[2] = 24'hFF0000;
    step();
    pix(4, 1'b1);
    pix(5, 1'b1);
    pix(4, 1'b0);
    pix_flush();
    pixel_stream(200, 1'b1);
  endtask

  task automatic test_underrun();
    int acks;
    hblank(5, 5, 1'b0, acks);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun set: got %b expected 1", underrun); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL underrun req: got %b expected 0", mem_req); end
    checks++;
    if (!(acks > 0 && acks < 80)) begin
      errors++; $display("FAIL underrun count: got %0d expected 1..79", acks);
    end
    check_addrs("underrun", 3, acks);
    model_fill(3, acks);
    underrun_clr = 1'b1;
    step();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun clr: got %b expected 0", underrun); end
    // Clear and abort together: the abort must win.
    hblank(5, 5, 1'b1, acks);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun prio: got %b expected 1", underrun); end
    model_fill(3, acks);
    underrun_clr = 1'b1;
    step();
    DrawY = 10'd6;
    pixel_stream(200, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    int acks;
    int held;
    DrawY   = 10'd7;
    blank   = 1'b0;
    ack_gap = 1;
    gap_cnt = 0;
    got_addr_q.delete();
    DrawX = 10'd639;
    step();
    step();
    for (int x = 640; x < 700 && got_addr_q.size() < 41; x++) begin
      DrawX = 10'(x);
      step();
    end
    held = got_addr_q.size();
    Reset   = 1'b1;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid req: got %b expected 0", mem_req); end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      errors++; $display("FAIL rst_mid rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B});
    end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid state: got %0d expected IDLE", dbg_state); end
    // Words consumed before reset are in the buffer; the refetch overwrites them.
    model_fill(4, held - 1);
    for (int i = 0; i < 16; i++) pal_m[i] = grey24(i);
    step();
    step();
    Reset = 1'b0;
    for (int x = 700; x < 800; x++) begin
      DrawX = 10'(x);
      step();
    end
    checks++;
    if (got_addr_q.size() !== held) begin
      errors++; $display("FAIL rst_mid no_restart: got %0d expected %0d", got_addr_q.size(), held);
    end
    hblank(7, 1, 1'b0, acks);
    checks++;
    if (acks !== 80) begin errors++; $display("FAIL rst_mid refetch: got %0d expected 80", acks); end
    check_addrs("rst_mid", 4, 80);
    model_fill(4, acks);
    DrawY = 10'd8;
    pixel_stream(200, 1'b1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    Reset        = 1'b1;
    DrawX        = '0;
    DrawY        = '0;
    blank        = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    pal_we       = 1'b0;
    pal_addr     = '0;
    pal_data     = '0;
    underrun_clr = 1'b0;
    ack_gap      = 1;
    gap_cnt      = 0;
    for (int i = 0; i < MEM_WORDS; i++) mem_img[i] = 16'($urandom);
    mem_img[0] = 16'h3210;
    for (int i = 0; i < 80; i++) model_buf[i] = 16'h0;
    for (int i = 0; i < 16; i++) pal_m[i] = grey24(i);

    test_reset();
    test_line_fetch();
    test_odd_skip_wrap();
    test_pixel_path();
    test_blank_palette();
    test_underrun();
    test_reset_mid_fetch();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
